// File: rtl/gol_pkg.sv
// Shared types and elaboration helpers for the Game-of-Life frame streamer.
package gol_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_HI  = 3'd1,
    ST_HDR_LO  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int HDR_W = 16;

  // Header plus one byte per 8 cells.
  function automatic int frame_bytes(input int width);
    return width / 8 + 2;
  endfunction

  function automatic int side(input int width);
    return 1 << ($clog2(width) / 2);
  endfunction

  function automatic bit params_ok(input int width, input int gen_w);
    return (width % 8 == 0) && (gen_w >= 1) && (gen_w <= 15)
        && (side(width) * side(width) == width);
  endfunction

endpackage

// File: rtl/gol_stable_detect.sv
// Counts consecutive identical generations and raises a sticky stable flag.
module gol_stable_detect
  import gol_pkg::*;
#(
  parameter int WIDTH    = 256,
  parameter int STABLE_N = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample,
  input  logic [WIDTH-1:0] q,
  output logic             stable
);

  localparam int CW = $clog2(STABLE_N + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_N);

  logic [WIDTH-1:0] prv_q;
  logic [CW-1:0]    cnt;
  logic             first;

  // prv_q is only compared once first has dropped, so it needs no reset.
  always_ff @(posedge clk) begin
    if (sample) prv_q <= q;
  end

  // A load re-arms first so the new pattern is never compared against the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      first  <= 1'b1;
      stable <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      first  <= 1'b1;
      stable <= 1'b0;
    end else begin
      if (sample) begin
        first <= 1'b0;
        if (!first && (q == prv_q)) begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end else begin
          cnt <= '0;
        end
      end
      if (cnt == CNT_MAX) stable <= 1'b1;
    end
  end

endmodule

// File: rtl/gol_frame_streamer.sv
// Snapshots Game-of-Life generations and streams each as header + payload bytes.
module gol_frame_streamer
  import gol_pkg::*;
#(
  parameter int WIDTH    = 256,
  parameter int STABLE_N = 16,
  parameter int GEN_W    = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] q,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             stable,
  output logic             done,
  output logic [GEN_W-1:0] gen_count
);

  localparam int FRAME_BYTES = frame_bytes(WIDTH);
  localparam int NBYTES      = FRAME_BYTES - 2;
  localparam int KW          = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [KW-1:0]    K_LAST  = KW'(NBYTES - 1);
  localparam logic [GEN_W-1:0] GEN_MAX = '1;

  if (!params_ok(WIDTH, GEN_W)) begin : g_bad_params
    $error("gol_frame_streamer: WIDTH must be a square multiple of 8 and GEN_W in 1..15");
  end

  state_t           state, state_n;
  logic [KW-1:0]    k, k_n;
  logic             armed, sample, accept, cap, done_n;
  logic             valid_n, last_n;
  logic [7:0]       data_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic [HDR_W-1:0] hdr, hdr_n;
  logic [14:0]      gen_ext;

  assign sample  = armed & ~load;
  assign accept  = m_valid & m_ready;
  assign gen_ext = 15'(gen_count);

  gol_stable_detect #(
    .WIDTH   (WIDTH),
    .STABLE_N(STABLE_N)
  ) u_stable (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (load),
    .sample(sample),
    .q     (q),
    .stable(stable)
  );

  always_comb begin
    state_n = state;
    k_n     = k;
    done_n  = done;
    cap     = 1'b0;
    case (state)
      ST_IDLE: if (sample) begin
        cap     = 1'b1;
        state_n = ST_HDR_HI;
        k_n     = '0;
      end
      ST_HDR_HI: if (accept) state_n = ST_HDR_LO;
      ST_HDR_LO: if (accept) begin
        state_n = ST_PAYLOAD;
        k_n     = '0;
      end
      ST_PAYLOAD: if (accept) begin
        if (k == K_LAST) begin
          if (hdr[HDR_W-1]) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          k_n = k + 1'b1;
        end
      end
      default: ;
    endcase
    // Load never aborts a frame; it only releases a finished stream.
    if (load) begin
      done_n = 1'b0;
      if (state_n == ST_DONE) state_n = ST_IDLE;
    end

    shadow_n = cap ? q : shadow;
    hdr_n    = cap ? {stable, gen_ext} : hdr;

    // Outputs are precomputed from next state so they leave flops directly.
    valid_n = (state_n == ST_HDR_HI) || (state_n == ST_HDR_LO) || (state_n == ST_PAYLOAD);
    last_n  = (state_n == ST_PAYLOAD) && (k_n == K_LAST);
    case (state_n)
      ST_HDR_HI:  data_n = hdr_n[15:8];
      ST_HDR_LO:  data_n = hdr_n[7:0];
      ST_PAYLOAD: data_n = shadow_n[{k_n, 3'b000} +: 8];
      default:    data_n = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    shadow <= shadow_n;
    hdr    <= hdr_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k         <= '0;
      armed     <= 1'b0;
      gen_count <= '0;
      done      <= 1'b0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= 8'h00;
    end else begin
      state   <= state_n;
      k       <= k_n;
      done    <= done_n;
      m_valid <= valid_n;
      m_last  <= last_n;
      m_data  <= data_n;
      if (load) begin
        armed     <= 1'b1;
        gen_count <= '0;
      end else if (sample && (gen_count != GEN_MAX)) begin
        gen_count <= gen_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gol_frame_streamer.sv
// Directed bench for gol_frame_streamer: still life, blinker, backpressure, reload and reset.
module tb_gol_frame_streamer;

  localparam int W       = 256;
  localparam int M_NONE  = 0;
  localparam int M_STILL = 1;
  localparam int M_BLINK = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, load, m_ready;
  logic [W-1:0]  q;
  logic [7:0]    m_data;
  logic          m_valid, m_last, stable, done;
  logic [14:0]   gen_count;
  logic [7:0]    s_data;
  logic          s_valid, s_last, s_stable, s_done;
  logic [3:0]    s_gen;

  gol_frame_streamer #(.WIDTH(W), .STABLE_N(16), .GEN_W(15)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .q(q),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .stable(stable), .done(done), .gen_count(gen_count)
  );

  gol_frame_streamer #(.WIDTH(W), .STABLE_N(16), .GEN_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .load(load), .q(q),
    .m_data(s_data), .m_valid(s_valid), .m_ready(m_ready), .m_last(s_last),
    .stable(s_stable), .done(s_done), .gen_count(s_gen)
  );

  int total = 0;
  int bad = 0;
  int mode;
  int smp;
  bit armed_m;
  logic [7:0] got[$];
  bit         got_l[$];
  logic [7:0] sgot[$];
  int         ends[$];
  logic       pv, pr, pl;
  logic [7:0] pd;

  function automatic logic [W-1:0] pat(input int md, input int g);
    logic [W-1:0] p = '0;
    if (md == M_STILL) begin
      p[0] = 1'b1; p[1] = 1'b1; p[16] = 1'b1; p[17] = 1'b1;
    end else if (md == M_BLINK) begin
      if (g % 2 == 0) begin
        p[17] = 1'b1; p[18] = 1'b1; p[19] = 1'b1;
      end else begin
        p[2] = 1'b1; p[18] = 1'b1; p[34] = 1'b1;
      end
    end
    return p;
  endfunction

  function automatic logic [7:0] fbyte(input logic [15:0] h, input logic [W-1:0] p, input int i);
    if (i == 0) return h[15:8];
    if (i == 1) return h[7:0];
    return p[8*(i-2) +: 8];
  endfunction

  // One clock: log accepted bytes, advance the generation model, drive the next grid.
  task automatic tick();
    bit ld, ar;
    if (m_valid && m_ready) begin
      got.push_back(m_data);
      got_l.push_back(m_last);
      if (m_last) ends.push_back(smp);
    end
    if (s_valid && m_ready) sgot.push_back(s_data);
    pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
    ld = load; ar = armed_m;
    @(posedge clk);
    if (!rst_n) begin
      armed_m = 1'b0; smp = 0;
    end else if (ld) begin
      armed_m = 1'b1; smp = 0;
    end else if (ar) begin
      smp++;
    end
    #1;
    q = pat(mode, smp);
  endtask

  task automatic clear_log();
    got.delete(); got_l.delete(); sgot.delete(); ends.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; load = 1'b0; m_ready = 1'b1; mode = M_NONE;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    clear_log();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; m_ready = 1'b1; mode = M_STILL;
    tick();
    load = 1'b1; tick();
    load = 1'b0; tick();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0b want=0", m_valid); end
    total++; if (m_last !== 1'b0) begin bad++; $display("FAIL reset_m_last got=%0b want=0", m_last); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_m_data got=%02h want=00", m_data); end
    total++; if (stable !== 1'b0) begin bad++; $display("FAIL reset_stable got=%0b want=0", stable); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
    total++; if (gen_count !== 15'd0) begin bad++; $display("FAIL reset_gen got=%0d want=0", gen_count); end
    rst_n = 1'b1;
    repeat (5) tick();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL unarmed_m_valid got=%0b want=0", m_valid); end
    total++; if (gen_count !== 15'd0) begin bad++; $display("FAIL unarmed_gen got=%0d want=0", gen_count); end
  endtask

  task automatic test_still_life();
    int vad = 0;
    logic [15:0] h;
    do_reset();
    mode = M_STILL; load = 1'b1; tick(); load = 1'b0;
    for (int t = 0; t < 130; t++) begin
      tick();
      if (smp == 17) begin
        total++; if (stable !== 1'b0) begin bad++; $display("FAIL still_stable_early got=%0b want=0", stable); end
        total++; if (gen_count !== 15'd17) begin bad++; $display("FAIL still_gen got=%0d want=17", gen_count); end
      end
      if (smp == 18) begin
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL still_stable_rise got=%0b want=1", stable); end
      end
      if (smp == 60) begin
        total++; if (done !== 1'b0) begin bad++; $display("FAIL still_done_early got=%0b want=0", done); end
      end
      if (done && m_valid) vad++;
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL still_done got=%0b want=1", done); end
    total++; if (vad != 0) begin bad++; $display("FAIL still_valid_after_done got=%0d want=0", vad); end
    total++; if (got.size() != 68) begin bad++; $display("FAIL still_bytes got=%0d want=68", got.size()); end
    for (int i = 0; i < got.size() && i < 68; i++) begin
      h = (i < 34) ? 16'h0000 : 16'h8023;
      total++;
      if (got[i] !== fbyte(h, pat(M_STILL, 0), i % 34) || got_l[i] != (i % 34 == 33)) begin
        bad++; $display("FAIL still_byte[%0d] got=%02h/last%0b want=%02h/last%0b", i, got[i], got_l[i],
                        fbyte(h, pat(M_STILL, 0), i % 34), (i % 34 == 33));
      end
    end
  endtask

  task automatic test_blinker();
    int g;
    logic [7:0] e, es;
    do_reset();
    mode = M_BLINK; load = 1'b1; tick(); load = 1'b0;
    repeat (105) tick();
    total++; if (got.size() != 102) begin bad++; $display("FAIL blink_bytes got=%0d want=102", got.size()); end
    total++; if (sgot.size() != 102) begin bad++; $display("FAIL sat_bytes got=%0d want=102", sgot.size()); end
    for (int i = 0; i < 102; i++) begin
      g = 35 * (i / 34);
      e = fbyte(16'(g), pat(M_BLINK, g), i % 34);
      es = fbyte(16'((g > 15) ? 15 : g), pat(M_BLINK, g), i % 34);
      if (i < got.size()) begin
        total++; if (got[i] !== e || got_l[i] != (i % 34 == 33)) begin
          bad++; $display("FAIL blink_byte[%0d] got=%02h want=%02h", i, got[i], e); end
      end
      if (i < sgot.size()) begin
        total++; if (sgot[i] !== es) begin bad++; $display("FAIL sat_byte[%0d] got=%02h want=%02h", i, sgot[i], es); end
      end
    end
    total++; if (stable !== 1'b0) begin bad++; $display("FAIL blink_stable got=%0b want=0", stable); end
    total++; if (gen_count !== 15'd105) begin bad++; $display("FAIL blink_gen got=%0d want=105", gen_count); end
    total++; if (s_gen !== 4'd15) begin bad++; $display("FAIL sat_gen got=%0d want=15", s_gen); end
  endtask

  task automatic test_backpressure();
    int nf, g;
    logic [7:0] e;
    do_reset();
    mode = M_BLINK; load = 1'b1; tick(); load = 1'b0;
    for (int t = 0; t < 400; t++) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      if (pv && !pr) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
          bad++; $display("FAIL bp_hold t=%0d got=%0b/%02h/%0b want=1/%02h/%0b", t, m_valid, m_data, m_last, pd, pl);
        end
      end
    end
    m_ready = 1'b1;
    nf = got.size() / 34;
    total++; if (nf < 3) begin bad++; $display("FAIL bp_frames got=%0d want>=3", nf); end
    for (int f = 0; f < nf; f++) begin
      g = (f == 0) ? 0 : ends[f-1] + 1;
      for (int b = 0; b < 34; b++) begin
        e = fbyte(16'(g), pat(M_BLINK, g), b);
        total++;
        if (got[f*34+b] !== e || got_l[f*34+b] != (b == 33)) begin
          bad++; $display("FAIL bp_frame%0d_byte%0d got=%02h want=%02h", f, b, got[f*34+b], e);
        end
      end
    end
  endtask

  task automatic test_load_mid_frame();
    logic [15:0] h;
    logic [W-1:0] p;
    do_reset();
    mode = M_STILL; m_ready = 1'b0; load = 1'b1; tick(); load = 1'b0;
    repeat (20) tick();
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL mid_stable_before got=%0b want=1", stable); end
    m_ready = 1'b1;
    repeat (12) tick();
    total++; if (got.size() != 12) begin bad++; $display("FAIL mid_pos got=%0d want=12", got.size()); end
    mode = M_BLINK; load = 1'b1; tick(); load = 1'b0;
    total++; if (stable !== 1'b0) begin bad++; $display("FAIL mid_stable_clr got=%0b want=0", stable); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_done got=%0b want=0", done); end
    total++; if (gen_count !== 15'd0) begin bad++; $display("FAIL mid_gen got=%0d want=0", gen_count); end
    repeat (56) tick();
    total++; if (got.size() != 68) begin bad++; $display("FAIL mid_bytes got=%0d want=68", got.size()); end
    for (int i = 0; i < got.size() && i < 68; i++) begin
      h = (i < 34) ? 16'h0000 : 16'h0015;
      p = (i < 34) ? pat(M_STILL, 0) : pat(M_BLINK, 21);
      total++;
      if (got[i] !== fbyte(h, p, i % 34) || got_l[i] != (i % 34 == 33)) begin
        bad++; $display("FAIL mid_byte[%0d] got=%02h want=%02h", i, got[i], fbyte(h, p, i % 34));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    do_reset();
    mode = M_BLINK; m_ready = 1'b1; load = 1'b1; tick(); load = 1'b0;
    while (!(m_valid && m_last) && n < 60) begin
      tick(); n++;
    end
    total++; if (m_last !== 1'b1) begin bad++; $display("FAIL rmid_reach_last got=%0b want=1 after %0d cycles", m_last, n); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rmid_m_valid got=%0b want=0", m_valid); end
    total++; if (m_last !== 1'b0) begin bad++; $display("FAIL rmid_m_last got=%0b want=0", m_last); end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rmid_after got=%0b want=0", m_valid); end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; m_ready = 1'b0; mode = M_NONE;
    smp = 0; armed_m = 1'b0; q = '0;
    test_reset();
    test_still_life();
    test_blinker();
    test_backpressure();
    test_load_mid_frame();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
